// File: rtl/cpa_acc_sched_if.sv
// +--------------------------------------------------------------------------+
// | cpa_acc_sched_if : control, stream-in and result channels of the CPA     |
// | accumulate scheduler.                                     rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cpa_acc_sched_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic             width;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;

  modport master (
    output start, width, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, width, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/cpa_acc_sched.sv
// +--------------------------------------------------------------------------+
// | cpa_acc_sched : streams words through one CPA32 into a 32-bit or dual    |
// | 16-bit accumulator and hands the sum downstream.          rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module cpa32 (
  input  wire logic [31:0] in_a,
  input  wire logic [31:0] in_b,
  input  wire logic        width,
  output logic      [31:0] sum
);
  logic [16:0] sum_lo;
  logic        carry_mid;
  logic [15:0] sum_hi;

  // Lane mode kills the carry out of bit 15 so each half wraps on its own.
  always_comb begin
    sum_lo    = {1'b0, in_a[15:0]} + {1'b0, in_b[15:0]};
    carry_mid = sum_lo[16] & ~width;
    sum_hi    = in_a[31:16] + in_b[31:16] + {15'd0, carry_mid};
    sum       = {sum_hi, sum_lo[15:0]};
  end
endmodule

module cpa_acc_sched #(
  parameter int LEN_W = 8
) (
  input wire logic          clk,
  input wire logic          rst_n,
  cpa_acc_sched_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             w_lat, w_nxt;
  logic [31:0]      cpa_sum;
  logic             in_ready_c;
  logic             out_valid_c;

  cpa32 u_cpa32 (
    .in_a  (acc),
    .in_b  (bus.in_data),
    .width (w_lat),
    .sum   (cpa_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      w_lat <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      w_lat <= w_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    w_nxt       = w_lat;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          // A zero-length job skips accumulation and presents zero at once.
          if (bus.len == '0) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = ACC;
            cnt_nxt   = bus.len;
            w_nxt     = bus.width;
          end
        end
      end
      ACC: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          acc_nxt = cpa_sum;
          cnt_nxt = cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = acc;
  assign bus.busy      = (state != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_cpa_acc_sched.sv
// +--------------------------------------------------------------------------+
// | tb_cpa_acc_sched : vector table plus corner sequences for cpa_acc_sched, |
// | results checked through an expected-value queue.          rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cpa_acc_sched;
  localparam int LEN_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cpa_acc_sched_if #(.LEN_W(LEN_W)) bus ();

  cpa_acc_sched #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             w;
    logic [LEN_W-1:0] len;
    logic [3:0][31:0] words;
    logic [31:0]      exp;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          beats = 0;
  logic [31:0] sb[$];
  vec_t        vecs[7];

  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) beats++;
  end

  function automatic vec_t mk(logic w, logic [LEN_W-1:0] l,
                              logic [31:0] a, logic [31:0] b,
                              logic [31:0] c, logic [31:0] d,
                              logic [31:0] e);
    vec_t v;
    v.w        = w;
    v.len      = l;
    v.words[0] = a;
    v.words[1] = b;
    v.words[2] = c;
    v.words[3] = d;
    v.exp      = e;
    return v;
  endfunction

  // Independent reference: each lane kept in its own 16-bit variable.
  function automatic logic [31:0] model_rep(logic w, int n, logic [31:0] word);
    logic [31:0] full;
    logic [15:0] lo, hi;
    full = '0; lo = '0; hi = '0;
    for (int i = 0; i < n; i++) begin
      full = full + word;
      lo   = lo + word[15:0];
      hi   = hi + word[31:16];
    end
    return w ? {hi, lo} : full;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic start_job(logic w, logic [LEN_W-1:0] l, logic [31:0] exp);
    bus.start    = 1'b1;
    bus.width    = w;
    bus.len      = l;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    sb.push_back(exp);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.width    = ~w;
    bus.len      = '1;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic feed_word(logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_job(string nm);
    bit          ok;
    logic [31:0] exp;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", nm);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: got result 0x%08h expected none", nm, bus.out_data);
    end else begin
      exp = sb.pop_front();
      if (bus.out_data !== exp) begin
        bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, bus.out_data, exp);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_ov_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({nm, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int b0;
    logic [31:0] held;

    vecs[0] = mk(1'b0, 8'd3, 32'hFFFF0001, 32'h0000FFFF, 32'h00000001, 32'h0, 32'h00000001);
    vecs[1] = mk(1'b1, 8'd3, 32'hFFFF0001, 32'h0000FFFF, 32'h00000001, 32'h0, 32'hFFFF0001);
    vecs[2] = mk(1'b0, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000000);
    vecs[3] = mk(1'b0, 8'd2, 32'h80008000, 32'h80008000, 32'h0, 32'h0, 32'h00010000);
    vecs[4] = mk(1'b1, 8'd2, 32'h80008000, 32'h80008000, 32'h0, 32'h0, 32'h00000000);
    vecs[5] = mk(1'b0, 8'd4, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A);
    vecs[6] = mk(1'b1, 8'd1, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h12345678);

    bus.start = 1'b0; bus.width = 1'b0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      b0 = beats;
      start_job(vecs[i].w, vecs[i].len, vecs[i].exp);
      if (vecs[i].len == '0) begin
        bus.in_valid = 1'b1;
        chk($sformatf("v%0d_zero_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
        chk($sformatf("v%0d_zero_ov", i), {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
      end else begin
        for (int j = 0; j < int'(vecs[i].len); j++) begin
          chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
          feed_word(vecs[i].words[j]);
        end
        chk($sformatf("v%0d_latency", i), {31'd0, bus.out_valid}, 32'd1);
      end
      chk($sformatf("v%0d_beats", i), beats - b0, {24'd0, vecs[i].len});
      finish_job($sformatf("v%0d_result", i));
    end

    // Bubbles upstream, back-pressure downstream, stray start while holding.
    b0 = beats;
    start_job(1'b0, 8'd4, 32'h0000000A);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      feed_word(32'(j + 1));
    end
    chk("bp_latency", {31'd0, bus.out_valid}, 32'd1);
    held = bus.out_data;
    for (int c = 0; c < 5; c++) begin
      bus.start    = (c == 2);
      bus.len      = 8'd2;
      bus.in_valid = 1'b1;
      chk("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("bp_hold_ov", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_hold_data", bus.out_data, held);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk("bp_beats", beats - b0, 32'd4);
    finish_job("bp_result");
    @(negedge clk);
    chk("bp_start_not_queued", {31'd0, bus.busy}, 32'd0);

    // Asynchronous abort after two of five beats.
    start_job(1'b0, 8'd5, 32'h0);
    feed_word(32'h11111111);
    feed_word(32'h22222222);
    bus.in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out_data", bus.out_data, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_result", {31'd0, bus.out_valid}, 32'd0);
    start_job(1'b0, 8'd1, 32'h12345678);
    feed_word(32'h12345678);
    chk("post_abort_latency", {31'd0, bus.out_valid}, 32'd1);
    finish_job("post_abort_result");

    // Longest job, lane mode, continuous stream.
    b0 = beats;
    start_job(1'b1, 8'd255, model_rep(1'b1, 255, 32'h00010001));
    for (int j = 0; j < 255; j++) feed_word(32'h00010001);
    chk("max_latency", {31'd0, bus.out_valid}, 32'd1);
    chk("max_beats", beats - b0, 32'd255);
    finish_job("max_result");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire

// File: doc/cpa_acc_sched.md
# cpa_acc_sched

Sequencing controller that owns one CPA32 vector carry-propagate adder and uses it to reduce a stream of 32-bit words into a single accumulated sum, in either full 32-bit mode or dual independent 16-bit lane mode. It sits between an upstream valid/ready word source, such as the MAC/partial-product pipeline, and a downstream valid/ready consumer. The block latches a job descriptor on `start`, feeds one accepted word per cycle through the adder, counts beats, and presents the result until it is taken.

## Interface
- `LEN_W`, default 8: width of the beat-count field. Maximum job length is 2^LEN_W − 1 beats.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request. Sampled only in IDLE.
- `width`  in  1  lane mode, latched on `start`. 0 = one 32-bit lane; 1 = two 16-bit lanes.
- `len`  in  LEN_W  number of words to accumulate, latched on `start`.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_data`  in  32  upstream word.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  32  accumulated result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Datapath: one instantiated CPA32 with `inA` = acc, `inB` = `in_data`, `width` = the latched width. Next acc = CPA32 output.
  - Width 0: sum is mod 2^32.
  - Width 1: each 16-bit lane sums mod 2^16. There is no carry from bit 15 into bit 16.
- Registers: `acc[31:0]`, `cnt[LEN_W-1:0]`, `w_lat`, and the state.
- FSM states: IDLE, ACC, HOLD.
- IDLE to ACC: `start`=1 and `len`≠0. On that edge, acc←0, cnt←`len`, w_lat←`width`.
- IDLE to HOLD: `start`=1 and `len`=0. On that edge, acc←0. The result is 0x00000000.
- ACC:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: acc←CPA32(acc, `in_data`, w_lat) and cnt←cnt−1.
  - If cnt=1 on an accepted beat, go to HOLD. Otherwise stay in ACC.
  - With no beat, nothing changes.
- HOLD:
  - `out_valid`=1 and `out_data`=acc.
  - On `out_ready`=1, go to IDLE. acc is retained, not cleared.
- `out_data` always drives acc. It is meaningful only while `out_valid`=1.
- `start` outside IDLE is ignored; it is not queued.
- `width` and `len` changes outside the `start` edge have no effect.
- `in_ready`=0 in IDLE and HOLD. Words presented then are not consumed.

## Timing
- Reset values (asynchronous, when `rst_n`=0): state=IDLE, acc=0, cnt=0, w_lat=0. Outputs are `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- Reset asserted mid-job aborts the job immediately. No partial result is emitted.
- Job flow for `start` sampled at edge k:
  - Busy rises after edge k.
  - First possible beat acceptance is at edge k+1.
  - A `start` and an `in_valid` in the same IDLE cycle do not transfer a beat.
- With `in_valid` held high, N beats are accepted at edges k+1..k+N. `out_valid` rises after edge k+N.
  - Throughput is 1 word/cycle.
  - Latency from the last beat to `out_valid` is 1 cycle.
- `len`=0: `out_valid` rises after edge k, with `out_data`=0.
- Result handshake at edge m with `out_valid`&&`out_ready`:
  - After edge m, the state is IDLE and `out_valid`=0.
  - A new `start` can be sampled no earlier than edge m+1.
- `out_valid` stays high and `out_data` stays stable while `out_ready`=0, indefinitely.
- Upstream bubbles (`in_valid`=0) stall ACC with no state change. There is no timeout.
- The adder path is combinational in one cycle, from the acc register through CPA32 back to the acc register.

## Test plan
- Full-width wrap: `width`=0, `len`=3, words 0xFFFF0001, 0x0000FFFF, 0x00000001 → `out_data`=0x00000001. `out_valid` rises 1 cycle after the 3rd beat.
- Lane mode, same words: `width`=1, `len`=3 → `out_data`=0xFFFF0001. This shows no carry across bit 16 and a per-lane wrap.
- Zero length: `start` with `len`=0 → `out_valid` after 1 edge with `out_data`=0x00000000. `in_ready` is never asserted.
- Back-pressure and bubbles:
  - Setup: `len`=4, words 1, 2, 3, 4 with `in_valid` toggling, and `out_ready` held low 5 cycles.
  - Required: exactly 4 beats accepted and `out_data`=0x0000000A held stable.
  - Required: a `start` issued during HOLD is ignored, and after the handshake the block returns to IDLE.
- Reset mid-job: `rst_n` pulled low after 2 of 5 beats → all outputs 0 immediately and the state is IDLE. A new `len`=1 job with word 0x12345678 then returns 0x12345678.
- Max length: `len`=2^LEN_W−1=255, all words 0x00010001, `width`=1 → `out_data`=0x00FF00FF after 255 continuous beats.
